// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus-cycle initiator: command codes,
// FSM state codes, the latched request record and per-command T-state counts.
package z80_bus_pkg;

  // Request command encodings; 5..7 are reserved and never start a cycle.
  localparam logic [2:0] CMD_FETCH = 3'd0;
  localparam logic [2:0] CMD_MEMRD = 3'd1;
  localparam logic [2:0] CMD_MEMWR = 3'd2;
  localparam logic [2:0] CMD_IORD  = 3'd3;
  localparam logic [2:0] CMD_IOWR  = 3'd4;

  // Bus FSM states, kept as plain constants so older tools and netlists
  // see a fixed encoding.
  typedef logic [2:0] bus_state_t;
  localparam bus_state_t ST_IDLE = 3'd0;
  localparam bus_state_t ST_T1   = 3'd1;
  localparam bus_state_t ST_T2   = 3'd2;
  localparam bus_state_t ST_TW   = 3'd3;
  localparam bus_state_t ST_T3   = 3'd4;
  localparam bus_state_t ST_T4   = 3'd5;

  // Request fields that must survive past the acceptance edge.
  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] wdata;
  } bus_req_t;

  // Nominal T-states per command with no wait requests; 0 marks a reserved code.
  function automatic logic [2:0] t_states(input logic [2:0] c);
    case (c)
      CMD_FETCH: t_states = 3'd4;
      CMD_MEMRD: t_states = 3'd3;
      CMD_MEMWR: t_states = 3'd3;
      CMD_IORD:  t_states = 3'd4;
      CMD_IOWR:  t_states = 3'd4;
      default:   t_states = 3'd0;
    endcase
  endfunction

  function automatic logic cmd_legal(input logic [2:0] c);
    cmd_legal = (t_states(c) != 3'd0);
  endfunction

endpackage

// File: rtl/z80_clk_div.sv
// CPU clock generator: divides clk28 into a 50% duty clkcpu and flags the
// clk28 edges on which clkcpu rises (T-state start) and falls (F phase).
module z80_clk_div #(
  parameter int HALF_T = 4
) (
  input  logic clk28,
  input  logic rst,
  output logic clkcpu,
  output logic t_rise,
  output logic t_fall
);

  localparam logic [3:0] LAST = 4'(HALF_T - 1);

  logic [3:0] cnt;
  logic       wrap;

  assign wrap   = (cnt == LAST);
  // Strobes mark the edge on which clkcpu is about to change, so bus logic
  // updates on the very same clk28 edge as clkcpu.
  assign t_rise = wrap & ~clkcpu;
  assign t_fall = wrap &  clkcpu;

  // Half-period counter; clkcpu toggles on every wrap.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      cnt    <= 4'd0;
      clkcpu <= 1'b1;
    end else if (wrap) begin
      cnt    <= 4'd0;
      clkcpu <= ~clkcpu;
    end else begin
      cnt    <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus-cycle initiator: turns a req/done handshake into T-state accurate
// opcode fetch (with refresh), memory read/write and I/O read/write cycles.
//
// state | meaning
// IDLE  | no cycle; request accepted on a T-state rising edge
// T1    | address out; MREQ/RD (or data out) asserted at the F phase
// T2    | I/O strobes at R; memory wait sampled at F
// TW    | wait state; n_wait resampled at each F
// T3    | fetch: data captured at R, refresh starts; others finish at F
// T4    | fetch refresh tail; cycle ends at the next rising edge
module z80_bus_master
  import z80_bus_pkg::*;
#(
  parameter int         HALF_T  = 4,
  parameter logic [7:0] RFSH_HI = 8'h3F
) (
  input  logic        clk28,
  input  logic        rst,
  output logic        clkcpu,
  input  logic        req,
  input  logic [2:0]  cmd,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [15:0] a,
  output logic [7:0]  d_o,
  output logic        d_oe,
  input  logic [7:0]  d_i,
  output logic        n_m1,
  output logic        n_mreq,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_rfsh,
  input  logic        n_wait
);

  logic       t_rise;
  logic       t_fall;
  bus_state_t state;
  bus_req_t   cur;
  logic       wait_q;
  logic [6:0] r_cnt;

  logic is_fetch;
  logic is_io;
  logic is_rd;
  logic forced_tw;
  logic goto_t3;

  z80_clk_div #(
    .HALF_T (HALF_T)
  ) u_clk_div (
    .clk28  (clk28),
    .rst    (rst),
    .clkcpu (clkcpu),
    .t_rise (t_rise),
    .t_fall (t_fall)
  );

  // Command decode of the latched request and the T2/TW exit decision.
  always_comb begin
    is_fetch  = (cur.cmd == CMD_FETCH);
    is_io     = (cur.cmd == CMD_IORD) || (cur.cmd == CMD_IOWR);
    is_rd     = (cur.cmd == CMD_MEMRD) || (cur.cmd == CMD_IORD);
    // The fourth T-state of a non-fetch cycle is the mandatory I/O wait state.
    forced_tw = (t_states(cur.cmd) == 3'd4) && !is_fetch;
    goto_t3   = !wait_q && !((state == ST_T2) && forced_tw);
  end

  // Bus sequencer: every bus change happens on a clkcpu edge (divider wrap).
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cur    <= '0;
      wait_q <= 1'b0;
      r_cnt  <= 7'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= 8'h00;
      a      <= 16'h0000;
      d_o    <= 8'h00;
      d_oe   <= 1'b0;
      n_m1   <= 1'b1;
      n_mreq <= 1'b1;
      n_iorq <= 1'b1;
      n_rd   <= 1'b1;
      n_wr   <= 1'b1;
      n_rfsh <= 1'b1;
    end else begin
      done <= 1'b0;
      if (t_rise) begin
        case (state)
          ST_IDLE: begin
            // Write data from a finished memory write is released here.
            d_oe <= 1'b0;
            if (req && cmd_legal(cmd)) begin
              cur   <= '{cmd: cmd, wdata: wdata};
              state <= ST_T1;
              busy  <= 1'b1;
              a     <= addr;
              n_m1  <= (cmd != CMD_FETCH);
              if (cmd == CMD_IOWR) begin
                d_o  <= wdata;
                d_oe <= 1'b1;
              end
            end
          end
          ST_T1: begin
            state <= ST_T2;
            if (is_io) begin
              n_iorq <= 1'b0;
              if (cur.cmd == CMD_IORD) n_rd <= 1'b0;
              else                     n_wr <= 1'b0;
            end
          end
          ST_T2, ST_TW: begin
            if (goto_t3) begin
              state <= ST_T3;
              if (is_fetch) begin
                rdata  <= d_i;
                n_mreq <= 1'b1;
                n_rd   <= 1'b1;
                n_m1   <= 1'b1;
                a      <= {RFSH_HI, 1'b0, r_cnt};
                n_rfsh <= 1'b0;
              end
            end else begin
              state <= ST_TW;
            end
          end
          ST_T3: begin
            // Only a fetch is still in T3 at a rising edge.
            state <= ST_T4;
          end
          ST_T4: begin
            n_rfsh <= 1'b1;
            r_cnt  <= r_cnt + 7'd1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (t_fall) begin
        case (state)
          ST_T1: begin
            if (!is_io) begin
              n_mreq <= 1'b0;
              if (cur.cmd == CMD_MEMWR) begin
                d_o  <= cur.wdata;
                d_oe <= 1'b1;
              end else begin
                n_rd <= 1'b0;
              end
            end
          end
          ST_T2: begin
            if (cur.cmd == CMD_MEMWR) n_wr <= 1'b0;
            // I/O ignores n_wait here; its first sample is in the forced TW.
            if (!forced_tw) wait_q <= ~n_wait;
          end
          ST_TW: begin
            wait_q <= ~n_wait;
          end
          ST_T3: begin
            if (is_fetch) begin
              n_mreq <= 1'b0;
            end else begin
              if (is_rd) rdata <= d_i;
              n_mreq <= 1'b1;
              n_iorq <= 1'b1;
              n_rd   <= 1'b1;
              n_wr   <= 1'b1;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end
          end
          ST_T4: begin
            n_mreq <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
